// File: rtl/struct_list.sv
// Shared AXI read-channel structs and constants for the DDR read/write masters
// and the read arbiter.
package struct_list;

  localparam logic HI = 1'b1;
  localparam logic LO = 1'b0;

  localparam int RID_W      = 1;
  localparam int RD_REQ_NUM = 2;

  typedef struct packed {
    logic [RID_W-1:0] id;
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic             valid;
  } AXI_AR;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        valid;
  } AXI_R;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// One AXI read port (AR + R channels) as seen between a read client and the
// DDR side; the R id travels separately because only the master side has one.
interface axi_rd_arbiter_if;
  import struct_list::*;

  AXI_AR ar;
  logic  arready;
  AXI_R  r;
  logic  rready;

  modport master (output ar, output rready, input arready, input r);
  modport slave  (input ar, input rready, output arready, output r);

endinterface

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-way round-robin grant: on contention the requester named by ptr wins,
// otherwise the single requester wins. Purely combinational.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    gnt_idx = req[1];
    gnt     = 2'b00;
    if (&req) gnt_idx = ptr;
    if (|req) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one DDR AXI read master between the HDMI line fetch (req 0) and the
// filter/aux reader (req 1), with per-requester outstanding-burst limits.
module axi_rd_arbiter
  import struct_list::*;
#(
  parameter int MAX_OUT = 2,
  parameter int CNT_W   = 2
) (
  input  logic             clk_i,
  input  logic             rst_n,
  axi_rd_arbiter_if.slave  s0,
  axi_rd_arbiter_if.slave  s1,
  axi_rd_arbiter_if.master m,
  input  logic [RID_W-1:0] m_rid,
  output logic             busy,
  output logic             rr_ptr
);

  localparam logic [0:0]       IDLE    = 1'b0;
  localparam logic [0:0]       ISSUE   = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

  logic [0:0]       state;
  logic             grant;
  AXI_AR            ar_q;
  AXI_AR            ar_next;
  logic [CNT_W-1:0] out_cnt [RD_REQ_NUM];

  logic [1:0] elig;
  logic [1:0] gnt;
  logic       gnt_idx;
  logic       ar_hs;
  logic       r_last_hs;
  logic [1:0] inc;
  logic [1:0] dec;

  assign elig[0] = s0.ar.valid && (out_cnt[0] < CNT_MAX);
  assign elig[1] = s1.ar.valid && (out_cnt[1] < CNT_MAX);

  rr_arb2 u_arb (
    .req     (elig),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // The winner's request is re-tagged with its own index so R beats can be
  // steered back by rid.
  always_comb begin
    ar_next       = gnt[0] ? s0.ar : s1.ar;
    ar_next.id    = RID_W'(gnt_idx);
    ar_next.valid = HI;
  end

  assign ar_hs     = (state == ISSUE) && m.arready && ar_q.valid;
  assign r_last_hs = m.r.valid && m.rready && m.r.last;

  always_comb begin
    for (int k = 0; k < RD_REQ_NUM; k++) begin
      inc[k] = ar_hs && (grant == 1'(k)) && (out_cnt[k] < CNT_MAX);
      dec[k] = r_last_hs && (m_rid == RID_W'(k)) && (out_cnt[k] != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state is written with <= only, so every block sees the
    // pre-edge values regardless of evaluation order.
    if (!rst_n) begin
      state  <= IDLE;
      grant  <= 1'b0;
      ar_q   <= '0;
      rr_ptr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            ar_q  <= ar_next;
            grant <= gnt_idx;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (ar_hs) begin
            ar_q.valid <= LO;
            rr_ptr     <= ~grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A grant and a completion on the same counter in one cycle cancel out.
  always_ff @(posedge clk_i) begin
    // NOTE: out_cnt is a handful of flops, not a RAM, so it is reset directly.
    if (!rst_n) begin
      for (int k = 0; k < RD_REQ_NUM; k++) out_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < RD_REQ_NUM; k++) begin
        case ({inc[k], dec[k]})
          2'b10:   out_cnt[k] <= out_cnt[k] + CNT_W'(1);
          2'b01:   out_cnt[k] <= out_cnt[k] - CNT_W'(1);
          default: out_cnt[k] <= out_cnt[k];
        endcase
      end
    end
  end

  assign m.ar       = ar_q;
  assign s0.arready = (state == ISSUE) && (grant == 1'b0) && m.arready;
  assign s1.arready = (state == ISSUE) && (grant == 1'b1) && m.arready;

  assign m.rready = m_rid[0] ? s1.rready : s0.rready;

  always_comb begin
    s0.r       = m.r;
    s0.r.valid = m.r.valid && (m_rid == RID_W'(0));
  end

  always_comb begin
    s1.r       = m.r;
    s1.r.valid = m.r.valid && (m_rid == RID_W'(1));
  end

  assign busy = (state == ISSUE) || (out_cnt[0] != '0) || (out_cnt[1] != '0);

  // A last beat for a requester with nothing outstanding is dropped above;
  // outside of reset recovery it points at an interconnect bug.
  a_no_underflow: assert property (
    @(posedge clk_i) disable iff (!rst_n) !(r_last_hs && (out_cnt[m_rid] == '0))
  ) else $error("out_cnt underflow on rid %0d", m_rid);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomised bench for axi_rd_arbiter against a transaction-level reference
// model (outstanding counts, priority holder, pending AR) kept in plain ints.
module tb_axi_rd_arbiter;
  import struct_list::*;

  localparam int MAX_OUT = 2;

  logic clk_i = 1'b0;
  logic rst_n;
  always #5 clk_i = ~clk_i;

  axi_rd_arbiter_if s0_if ();
  axi_rd_arbiter_if s1_if ();
  axi_rd_arbiter_if m_if ();

  AXI_AR      ar_s [2];
  logic [1:0] rrdy_s;
  logic       arready_m;
  AXI_R       r_m;
  logic       rid_m;
  logic       busy;
  logic       rr_ptr;

  assign s0_if.ar     = ar_s[0];
  assign s0_if.rready = rrdy_s[0];
  assign s1_if.ar     = ar_s[1];
  assign s1_if.rready = rrdy_s[1];
  assign m_if.arready = arready_m;
  assign m_if.r       = r_m;

  axi_rd_arbiter #(.MAX_OUT(MAX_OUT), .CNT_W(2)) dut (
    .clk_i  (clk_i),
    .rst_n  (rst_n),
    .s0     (s0_if),
    .s1     (s1_if),
    .m      (m_if),
    .m_rid  (rid_m),
    .busy   (busy),
    .rr_ptr (rr_ptr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: is an AR waiting on the DDR side, whose is it, what was
  // presented, bursts outstanding per requester, who has priority.
  bit    md_issue;
  int    md_who;
  AXI_AR md_ar;
  int    md_cnt [2];
  int    md_rr;

  bit ar_acc [2];
  bit beat_acc;
  bit log_rx;

  int          pend0 [$];
  int          pend1 [$];
  logic [63:0] sent0 [$];
  logic [63:0] sent1 [$];
  logic [63:0] got0  [$];
  logic [63:0] got1  [$];

  function automatic AXI_AR mk_ar(input logic [31:0] addr, input logic [7:0] len);
    AXI_AR a;
    a       = '0;
    a.id    = 1'b1;
    a.addr  = addr;
    a.len   = len;
    a.size  = 3'd3;
    a.burst = 2'b01;
    a.valid = 1'b1;
    return a;
  endfunction

  task automatic model_edge(input logic rrdy);
    int pre [2];
    bit el [2];
    int w;
    ar_acc   = '{0, 0};
    beat_acc = 1'b0;
    if (!rst_n) begin
      md_issue = 1'b0;
      md_who   = 0;
      md_ar    = '0;
      md_cnt   = '{0, 0};
      md_rr    = 0;
      return;
    end
    pre      = md_cnt;
    beat_acc = r_m.valid && rrdy;
    if (md_issue) begin
      if (arready_m) begin
        ar_acc[md_who] = 1'b1;
        md_ar.valid    = 1'b0;
        md_rr          = 1 - md_who;
        md_cnt[md_who]++;
        md_issue       = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) el[k] = ar_s[k].valid && (pre[k] < MAX_OUT);
      if (el[0] || el[1]) begin
        w           = (el[0] && el[1]) ? md_rr : (el[1] ? 1 : 0);
        md_ar       = ar_s[w];
        md_ar.id    = w[0];
        md_ar.valid = 1'b1;
        md_who      = w;
        md_issue    = 1'b1;
      end
    end
    if (beat_acc && r_m.last && pre[rid_m] > 0) md_cnt[rid_m]--;
  endtask

  task automatic retire(input logic id);
    if (id == 1'b0 && pend0.size() > 0) begin
      pend0[0]--;
      if (pend0[0] == 0) void'(pend0.pop_front());
    end else if (id == 1'b1 && pend1.size() > 0) begin
      pend1[0]--;
      if (pend1[0] == 0) void'(pend1.pop_front());
    end
  endtask

  // Entered just after a rising edge with this cycle's inputs applied;
  // compares, advances the model across the next edge, returns 1 after it.
  task automatic cycle();
    logic [1:0] e_ardy;
    logic       e_rrdy;
    AXI_R       e_r [2];
    AXI_R       o_r [2];
    #1;
    e_rrdy = rid_m ? rrdy_s[1] : rrdy_s[0];
    for (int k = 0; k < 2; k++) begin
      e_ardy[k]    = md_issue && (md_who == k) && arready_m;
      e_r[k]       = r_m;
      e_r[k].valid = r_m.valid && (int'(rid_m) == k);
    end
    o_r[0] = s0_if.r;
    o_r[1] = s1_if.r;
    check("m_ar", m_if.ar, md_ar);
    check("s0_arready", s0_if.arready, e_ardy[0]);
    check("s1_arready", s1_if.arready, e_ardy[1]);
    check("m_rready", m_if.rready, e_rrdy);
    check("s0_r", o_r[0], e_r[0]);
    check("s1_r", o_r[1], e_r[1]);
    check("busy", busy, md_issue || md_cnt[0] != 0 || md_cnt[1] != 0);
    check("rr_ptr", rr_ptr, md_rr[0]);
    @(posedge clk_i);
    model_edge(e_rrdy);
    if (rst_n) begin
      if (ar_acc[0]) pend0.push_back(int'(md_ar.len) + 1);
      if (ar_acc[1]) pend1.push_back(int'(md_ar.len) + 1);
      if (beat_acc) begin
        retire(rid_m);
        if (log_rx) begin
          if (rid_m) got1.push_back(o_r[1].data);
          else       got0.push_back(o_r[0].data);
        end
      end
    end
    #1;
  endtask

  // Interconnect: returns beats of accepted bursts in per-id order, holding a
  // beat until it is taken; idle cycles carry garbage with a random rid.
  task automatic ic_step(input bit allow);
    if (r_m.valid && !beat_acc) return;
    r_m.data  = {$urandom, $urandom};
    r_m.resp  = 2'($urandom_range(0, 3));
    r_m.last  = 1'($urandom_range(0, 1));
    r_m.valid = 1'b0;
    rid_m     = 1'($urandom_range(0, 1));
    if (allow && (pend0.size() + pend1.size()) > 0 && $urandom_range(0, 3) != 0) begin
      if (pend0.size() == 0)      rid_m = 1'b1;
      else if (pend1.size() == 0) rid_m = 1'b0;
      r_m.valid = 1'b1;
      r_m.last  = rid_m ? (pend1[0] == 1) : (pend0[0] == 1);
    end
  endtask

  task automatic req_step(input bit allow);
    AXI_AR a;
    for (int k = 0; k < 2; k++) begin
      if (ar_acc[k]) ar_s[k].valid = 1'b0;
      if (!ar_s[k].valid && allow && $urandom_range(0, 2) == 0) begin
        a       = mk_ar($urandom, 8'($urandom_range(0, 3)));
        a.id    = 1'($urandom_range(0, 1));
        a.size  = 3'($urandom_range(0, 7));
        ar_s[k] = a;
      end
      rrdy_s[k] = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic drain(input int max_cyc);
    int t;
    t      = 0;
    rrdy_s = 2'b11;
    while (t < max_cyc && (pend0.size() != 0 || pend1.size() != 0 || r_m.valid ||
                           md_issue || ar_s[0].valid || ar_s[1].valid)) begin
      ic_step(1'b1);
      cycle();
      for (int k = 0; k < 2; k++) if (ar_acc[k]) ar_s[k].valid = 1'b0;
      t++;
    end
    check("drain_left", pend0.size() + pend1.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int    ord [$];
    int    c0, c1, t;
    AXI_AR exp_ar;

    rst_n     = 1'b0;
    ar_s[0]   = '0;
    ar_s[1]   = '0;
    rrdy_s    = 2'b11;
    arready_m = 1'b0;
    r_m       = '0;
    rid_m     = 1'b0;
    log_rx    = 1'b0;
    md_issue  = 1'b0;
    md_who    = 0;
    md_ar     = '0;
    md_cnt    = '{0, 0};
    md_rr     = 0;
    @(posedge clk_i);
    #1;
    repeat (2) cycle();
    check("rst_busy", busy, 1'b0);
    check("rst_ar_valid", m_if.ar.valid, 1'b0);
    rst_n = 1'b1;

    // Single long burst from the line fetch.
    ar_s[0]   = mk_ar(32'h0012_C000, 8'd239);
    arready_m = 1'b1;
    c0        = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (ar_acc[0]) begin
        c0++;
        ar_s[0].valid = 1'b0;
      end
    end
    check("p1_ar_pulses", c0, 1);
    drain(1000);
    check("p1_busy_end", busy, 1'b0);

    // Contention from priority 0: grants alternate until both are capped.
    rst_n = 1'b0;
    cycle();
    rst_n   = 1'b1;
    ar_s[0] = mk_ar(32'h1000, 8'd0);
    ar_s[1] = mk_ar(32'h2000, 8'd0);
    for (int i = 0; i < 20 && ord.size() < 4; i++) begin
      cycle();
      for (int k = 0; k < 2; k++) begin
        if (ar_acc[k]) begin
          ord.push_back(k);
          ar_s[k].addr += 32'h100;
        end
      end
    end
    ar_s[0].valid = 1'b0;
    ar_s[1].valid = 1'b0;
    check("p2_ord_len", ord.size(), 4);
    for (int i = 0; i < ord.size(); i++) check($sformatf("p2_ord%0d", i), ord[i], i % 2);
    drain(200);

    // Outstanding cap: s0 stalls at two, s1 still served, one completion frees s0.
    ar_s[0] = mk_ar(32'h3000, 8'd0);
    c0      = 0;
    c1      = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 6) ar_s[1] = mk_ar(32'h4000, 8'd0);
      cycle();
      if (ar_acc[0]) begin
        c0++;
        ar_s[0].addr += 32'h40;
      end
      if (ar_acc[1]) begin
        c1++;
        ar_s[1].valid = 1'b0;
      end
    end
    check("p3_s0_capped", c0, 2);
    check("p3_s1_granted", c1, 1);
    r_m       = '0;
    r_m.data  = 64'hA5;
    r_m.last  = 1'b1;
    r_m.valid = 1'b1;
    rid_m     = 1'b0;
    for (int i = 0; i < 8 && c0 < 3; i++) begin
      cycle();
      if (beat_acc) r_m.valid = 1'b0;
      if (ar_acc[0]) begin
        c0++;
        ar_s[0].valid = 1'b0;
      end
    end
    check("p3_s0_released", c0, 3);
    ar_s[0].valid = 1'b0;
    drain(200);

    // R routing: interleaved rids with s1 stalled for the first three cycles.
    ar_s[0] = mk_ar(32'h5000, 8'd2);
    ar_s[1] = mk_ar(32'h6000, 8'd2);
    for (int i = 0; i < 10 && (ar_s[0].valid || ar_s[1].valid); i++) begin
      cycle();
      for (int k = 0; k < 2; k++) if (ar_acc[k]) ar_s[k].valid = 1'b0;
    end
    rrdy_s = 2'b01;
    log_rx = 1'b1;
    t      = 0;
    for (int b = 0; b < 6; b++) begin
      rid_m     = (b % 2 == 0) ? 1'b1 : 1'b0;
      r_m.data  = {32'(b), $urandom};
      r_m.resp  = 2'b00;
      r_m.last  = (b >= 4);
      r_m.valid = 1'b1;
      if (rid_m) sent1.push_back(r_m.data);
      else       sent0.push_back(r_m.data);
      for (int w = 0; w < 8; w++) begin
        if (t >= 3) rrdy_s[1] = 1'b1;
        cycle();
        t++;
        if (beat_acc) break;
      end
    end
    r_m.valid = 1'b0;
    log_rx    = 1'b0;
    check("p4_rx0_n", got0.size(), 3);
    check("p4_rx1_n", got1.size(), 3);
    for (int i = 0; i < got0.size() && i < sent0.size(); i++) check($sformatf("p4_rx0_%0d", i), got0[i], sent0[i]);
    for (int i = 0; i < got1.size() && i < sent1.size(); i++) check($sformatf("p4_rx1_%0d", i), got1[i], sent1[i]);
    drain(200);

    // Same-edge AR handshake and last beat for requester 0.
    ar_s[0] = mk_ar(32'h7000, 8'd0);
    for (int i = 0; i < 6 && ar_s[0].valid; i++) begin
      cycle();
      if (ar_acc[0]) ar_s[0].valid = 1'b0;
    end
    ar_s[0] = mk_ar(32'h7100, 8'd0);
    for (int i = 0; i < 6 && !md_issue; i++) cycle();
    r_m.data  = 64'hBEEF;
    r_m.last  = 1'b1;
    r_m.valid = 1'b1;
    rid_m     = 1'b0;
    cycle();
    r_m.valid     = 1'b0;
    ar_s[0].valid = 1'b0;
    cycle();
    check("p5_cnt_held", busy, 1'b1);
    drain(200);
    check("p5_busy_end", busy, 1'b0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      arready_m = ($urandom_range(0, 2) != 0);
      req_step(1'b1);
      ic_step(1'b1);
      cycle();
    end
    arready_m = 1'b1;
    drain(3000);
    check("rand_busy_end", busy, 1'b0);

    // Backpressure in ISSUE, then reset with a burst still outstanding.
    ar_s[1] = mk_ar(32'h8000, 8'd3);
    for (int i = 0; i < 6 && ar_s[1].valid; i++) begin
      cycle();
      if (ar_acc[1]) ar_s[1].valid = 1'b0;
    end
    arready_m   = 1'b0;
    ar_s[0]     = mk_ar(32'h9000, 8'd5);
    exp_ar      = ar_s[0];
    exp_ar.id   = 1'b0;
    cycle();
    repeat (10) cycle();
    check("p7_ar_hold", m_if.ar, exp_ar);
    rst_n         = 1'b0;
    ar_s[0].valid = 1'b0;
    r_m.valid     = 1'b0;
    cycle();
    rst_n = 1'b1;
    pend0.delete();
    pend1.delete();
    check("p7_rst_ar_valid", m_if.ar.valid, 1'b0);
    check("p7_rst_busy", busy, 1'b0);
    check("p7_rst_rr", rr_ptr, 1'b0);
    check("p7_rst_arready", s0_if.arready, 1'b0);
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the single DDR AXI read master port between two read clients: req 0 is the HDMI line fetch and req 1 is the filter/aux read.
- Round-robin arbitration of AR requests, tagging each with id = requester index.
- Routes R beats back to the owning requester by rid.
- Per-requester outstanding-burst accounting, so one client cannot starve the other or overrun its line buffer.

Parameters:
- MAX_OUT, 2, max outstanding (issued, last beat not yet received) bursts per requester; 1..3
- CNT_W, 2, width of each outstanding counter; must hold MAX_OUT

Ports:
- clk_i  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- s0_ar  in  AXI_AR  requester 0 read address (id field ignored)
- s0_arready  out  1  AR accepted for requester 0
- s0_r  out  AXI_R  read data to requester 0
- s0_rready  in  1  requester 0 ready for R
- s1_ar  in  AXI_AR  requester 1 read address (id field ignored)
- s1_arready  out  1  AR accepted for requester 1
- s1_r  out  AXI_R  read data to requester 1
- s1_rready  in  1  requester 1 ready for R
- m_ar  out  AXI_AR  to DDR interconnect
- m_arready  in  1  interconnect AR ready
- m_r  in  AXI_R  from interconnect
- m_rid  in  1  interconnect R id
- m_rready  out  1  R ready to interconnect
- busy  out  1  any outstanding burst or AR in flight
- rr_ptr  out  1  current priority holder (debug)

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; m_ar all zero incl. valid; s*_arready=0; outstanding counters 0; rr_ptr=0; busy=0.
- Eligibility: eligible_k = sk_ar.valid && out_cnt_k < MAX_OUT.
- AR state machine IDLE, ISSUE.
  - IDLE: if any requester eligible, grant it. If both are eligible, grant the one equal to rr_ptr. Next cycle m_ar is registered from the granted struct, with id forced to the grant index and valid=1; state goes to ISSUE.
  - ISSUE: m_ar held stable until m_arready && m_ar.valid.
  - On that edge: m_ar.valid<=0; sk_arready pulses 1 for exactly that cycle (combinational: state==ISSUE && grant==k && m_arready); rr_ptr<=~grant; out_cnt_grant increments; state goes to IDLE.
  - Minimum AR-to-AR spacing is 2 cycles.
- Requester rule: sk_ar must stay stable while valid and not yet accepted. The arbiter samples the address only in IDLE.
- R routing, combinational:
  - sk_r = m_r with valid gated by (m_rid==k); other fields passed through.
  - m_rready = m_rid ? s1_rready : s0_rready.
  - An invalid m_r with unknown rid is still routed by rid; this is harmless.
- Completion: beat with m_r.valid && m_rready && m_r.last decrements out_cnt[m_rid].
- Simultaneous increment and decrement on the same counter in one cycle: count unchanged.
- Counter guards: never exceed MAX_OUT, never go below 0. An underflow attempt (last with count 0) is ignored and flagged by an assertion.
- busy = (state==ISSUE) || |out_cnt.
- Reset mid-burst: all state is cleared, and beats arriving afterwards are dropped by the counter guard. The system resets the interconnect together with this block.
- No combinational path from s*_ar to m_ar; single registered stage.

Decomposition:
- Shared package (struct_list): AXI_AR and AXI_R typedefs, plus the HI/LO constants and the rid width. These are already in use by the read/write masters; add RD_REQ_NUM=2.
- One sub-module: rr_arb2, a 2-way round-robin grant.
  - Inputs: req[1:0], ptr.
  - Outputs: gnt[1:0], gnt_idx.
  - Combinational; reusable for a later write-channel arbiter.

Test Plan:
- Single request: s0_ar addr=0x12C000 len=239, m_arready tied 1.
  - m_ar.valid rises 1 cycle after s0_ar.valid, with addr 0x12C000, id=0.
  - s0_arready pulses once; out_cnt0=1.
  - After 240 beats with last on beat 240: out_cnt0=0, busy=0.
- Contention: s0 and s1 both valid continuously, rr_ptr=0, fast ready.
  - Grant order is 0,1,0,1.
  - m_ar.id alternates; each arready pulse goes only to the matching requester.
- Outstanding cap: s0 keeps requesting, no R beats returned, MAX_OUT=2.
  - Exactly 2 ARs issued for s0; third not granted while s1 still gets granted.
  - One last beat for id 0 releases a third s0 grant.
- R routing: interleave beats rid=1 then rid=0, s1_rready=0 for 3 cycles.
  - m_rready=0 during those cycles; s0_r.valid never asserts on rid=1 beats.
  - Data arrives in order at each requester.
- Simultaneous events: AR handshake for s0 in the same cycle as the last beat of a prior s0 burst.
  - out_cnt0 unchanged (1 stays 1).
- Backpressure and reset: hold m_arready=0 for 10 cycles in ISSUE.
  - m_ar stable; then assert rst_n=0 for 1 cycle.
  - Next cycle m_ar.valid=0, counters 0, state IDLE, rr_ptr=0.
